cic_decim_comb: RTL and testbench
=================================

Name: cic_decim_comb

Overview:
- Downstream partner of the 3-stage CIC integrator. Consumes its wide accumulator output and valid strobe.
- Decimates by R by keeping every R-th valid sample.
- Runs three pipelined comb (differentiator) stages with differential delay M=1.
- Scales the result to the output width, completing the CIC decimation filter.

Parameters:
- IN_W, 21, input sample width; equals the integrator's output width, NIN + 3*log2(R).
- R, 8, decimation ratio; legal range 2..256.
- CNT_W, 8, decimation counter width; must satisfy 2^CNT_W >= R.
- OUT_W, 12, output width; OUT_W <= IN_W. The output keeps the MSBs of the comb result (drops IN_W-OUT_W LSBs).

Ports:
- clk  input  1  single clock; all registers on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_valid  input  1  one-cycle strobe per integrator sample (the integrator's valid).
- din  input  IN_W  integrator output; two's-complement, wrap-around domain.
- dout_valid  output  1  one-cycle strobe per decimated output sample.
- dout  output  OUT_W  filtered, decimated, scaled sample, signed.
- phase  output  CNT_W  current decimation counter value, for debug and alignment.

Behaviour:
- Reset (rst high, async): all outputs, counter, delay registers and pipeline valids go to 0. The filter restarts cleanly after release; reset mid-operation drops any in-flight samples.
- Decimation counter
  - cnt increments only on cycles with din_valid=1.
  - When din_valid=1 and cnt==R-1: cnt wraps to 0, din is captured into dec_reg, and dec_v pulses for 1 cycle.
  - Cycles with din_valid=0 leave cnt unchanged, so gaps of any length are legal.
- Comb stage k (k=1..3), enabled by its input valid v(k-1):
  - y_k <= x_k - z_k
  - z_k <= x_k
  - v_k <= v(k-1)
  - When the valid is low, y_k and z_k hold; v_k still follows v(k-1), so it returns to 0.
  - Stage 1 input is dec_reg/dec_v.
  - All arithmetic is IN_W bits, modulo 2^IN_W. Wrap is required (CIC relies on it); no saturation inside the combs.
- Scaling: dout = y_3[IN_W-1 : IN_W-OUT_W] (truncation toward minus infinity). Registered together with dout_valid.
- Latency: if din_valid is sampled high with cnt==R-1 at edge E, then dout_valid=1 and dout is valid in the cycle after edge E+4. Fixed latency of 4 edges; dout_valid is exactly 1 cycle wide.
- Between strobes, dout holds its last value.
- Throughput: one output per R valid inputs. Back-to-back din_valid is fully supported.
- Simultaneous events: rst dominates everything.
- No state machine beyond the counter; pipeline stages are independent registers gated by their valids.

Optional Feature:
- Macro CIC_COMB_ROUND_EN.
- Defined:
  - Before scaling, add 2^(IN_W-OUT_W-1) to y_3 (round half up).
  - If the addition overflows the signed range, clamp dout to the max positive value 2^(OUT_W-1)-1.
  - When IN_W==OUT_W, no rounding is applied.
  - Latency unchanged.
- Undefined: plain truncation as above.

Test Plan:
- Impulse, R=8, OUT_W=21: din=5 constant with din_valid every cycle from reset.
  - First dout_valid appears 4 edges after the 8th valid.
  - Successive outputs: 5, -10, 5, 0, 0.
- Ramp, R=4, OUT_W=21: din=0,1,2,... on every cycle.
  - Decimated samples are 3, 7, 11, 15.
  - dout sequence: 3, -2, -1, 0, 0. phase cycles 0,1,2,3.
- Gapped valid: din_valid high every 3rd cycle, R=8.
  - One dout_valid per 8 valids, exactly 4 edges after the accepting edge.
  - phase holds across gaps.
- Wrap-around, R=2, OUT_W=21: decimated samples 0x1FFFFF then 0x000001.
  - Stage-1 difference is 0x000002. No sticky error; later outputs stay correct.
- Reset mid-operation: assert rst while a sample is in stage 2.
  - Immediately dout=0, dout_valid=0, phase=0.
  - After release, the first output appears after R fresh valids plus 4 edges.
- Scaling, IN_W=21, OUT_W=12: y_3=0x000300 (768) gives dout=1 (truncate).
  - With CIC_COMB_ROUND_EN, dout=2 (768+256=1024, >>9).
  - y_3=0x0FFFFF with rounding gives dout=0x7FF (clamped).

Source files
------------

// File: rtl/cic_decim_comb.sv
// cic_decim_comb: decimator + 3-stage comb section of a CIC decimation filter.
// Takes the wide wrap-around output of the 3-stage CIC integrator, keeps every
// R-th valid sample, runs three M=1 comb stages and scales the result to OUT_W.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din_valid   one-cycle strobe per integrator sample
//   din         integrator output (IN_W, two's complement, wrap-around)
//   dout_valid  one-cycle strobe per decimated output sample
//   dout        filtered, decimated, scaled sample (OUT_W, signed)
//   phase       current decimation counter value
//
// Build option: define CIC_COMB_ROUND_EN to round half up (with positive clamp)
// instead of truncating when dropping the IN_W-OUT_W LSBs.
module cic_decim_comb #(
    parameter int unsigned IN_W  = 21,
    parameter int unsigned R     = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    output logic             dout_valid,
    output logic [OUT_W-1:0] dout,
    output logic [CNT_W-1:0] phase
);

    localparam int unsigned SH    = IN_W - OUT_W;
    localparam int unsigned NSTG  = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  dec_reg;
    logic             dec_v;

    logic [NSTG-1:0][IN_W-1:0] y;
    logic [NSTG-1:0][IN_W-1:0] z;
    logic [NSTG-1:0]           v;

    logic [NSTG-1:0][IN_W-1:0] x_c;
    logic [NSTG-1:0]           vin_c;

    logic [OUT_W-1:0] scaled_c;

    // Decimation counter: advances only on valid input, captures every R-th sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            dec_reg <= '0;
            dec_v   <= 1'b0;
        end else begin
            dec_v <= 1'b0;
            if (din_valid) begin
                if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    dec_reg <= din;
                    dec_v   <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign phase = cnt;

    // Stage input chaining: stage 0 fed by the decimator, later stages by the previous comb.
    always_comb begin
        x_c[0]   = dec_reg;
        vin_c[0] = dec_v;
        for (int k = 1; k < int'(NSTG); k++) begin
            x_c[k]   = y[k-1];
            vin_c[k] = v[k-1];
        end
    end

    // Comb stages: y = x - x[n-1], modulo 2^IN_W; values hold while the valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
            z <= '0;
            v <= '0;
        end else begin
            for (int k = 0; k < int'(NSTG); k++) begin
                v[k] <= vin_c[k];
                if (vin_c[k]) begin
                    y[k] <= x_c[k] - z[k];
                    z[k] <= x_c[k];
                end
            end
        end
    end

`ifdef CIC_COMB_ROUND_EN
    // Round half up; a positive overflow of the sum clamps to the max positive code.
    generate
        if (SH == 0) begin : g_no_round
            assign scaled_c = OUT_W'(y[NSTG-1]);
        end else begin : g_round
            localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SH - 1);
            logic [IN_W:0] sum_c;
            logic          ovf_c;
            assign sum_c    = {y[NSTG-1][IN_W-1], y[NSTG-1]} + HALF;
            assign ovf_c    = sum_c[IN_W] ^ sum_c[IN_W-1];
            assign scaled_c = ovf_c ? {1'b0, {(OUT_W - 1){1'b1}}}
                                    : OUT_W'(sum_c >> SH);
        end
    endgenerate
`else
    // Keep the MSBs (truncation toward minus infinity).
    assign scaled_c = OUT_W'(y[NSTG-1] >> SH);
`endif

    // Output register: dout holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            dout_valid <= v[NSTG-1];
            if (v[NSTG-1]) begin
                dout <= scaled_c;
            end
        end
    end

endmodule

// File: tb/tb_cic_decim_comb.sv
// tb_cic_decim_comb: directed bench for cic_decim_comb. Four instances cover the
// parameter sets needed (R=8/4/2 at full width, R=8 scaled to 12 bits).
module tb_cic_decim_comb;

    logic        clk;
    logic        rst;
    logic        dv_in  [4];
    logic [20:0] din_in [4];
    logic        dv_o   [4];
    logic [7:0]  ph_o   [4];
    logic [31:0] dout_o [4];

    logic [20:0] dout_a, dout_b, dout_c;
    logic [11:0] dout_d;

    int n_tests;
    int n_fail;
    logic [31:0] exp_q[$];

`ifdef CIC_COMB_ROUND_EN
    localparam int SC768 = 2;
`else
    localparam int SC768 = 1;
`endif

    cic_decim_comb #(.IN_W(21), .R(8), .CNT_W(8), .OUT_W(21)) u_a (
        .clk(clk), .rst(rst), .din_valid(dv_in[0]), .din(din_in[0]),
        .dout_valid(dv_o[0]), .dout(dout_a), .phase(ph_o[0]));
    cic_decim_comb #(.IN_W(21), .R(4), .CNT_W(8), .OUT_W(21)) u_b (
        .clk(clk), .rst(rst), .din_valid(dv_in[1]), .din(din_in[1]),
        .dout_valid(dv_o[1]), .dout(dout_b), .phase(ph_o[1]));
    cic_decim_comb #(.IN_W(21), .R(2), .CNT_W(8), .OUT_W(21)) u_c (
        .clk(clk), .rst(rst), .din_valid(dv_in[2]), .din(din_in[2]),
        .dout_valid(dv_o[2]), .dout(dout_c), .phase(ph_o[2]));
    cic_decim_comb #(.IN_W(21), .R(8), .CNT_W(8), .OUT_W(12)) u_d (
        .clk(clk), .rst(rst), .din_valid(dv_in[3]), .din(din_in[3]),
        .dout_valid(dv_o[3]), .dout(dout_d), .phase(ph_o[3]));

    assign dout_o[0] = {11'b0, dout_a};
    assign dout_o[1] = {11'b0, dout_b};
    assign dout_o[2] = {11'b0, dout_c};
    assign dout_o[3] = {20'b0, dout_d};

    always #5 clk = ~clk;

    function automatic logic [31:0] e21(input int v);
        logic [20:0] t;
        t = 21'(v);
        return {11'b0, t};
    endfunction

    function automatic logic [31:0] e12(input int v);
        logic [11:0] t;
        t = 12'(v);
        return {20'b0, t};
    endfunction

    function automatic int r_of(input int sel);
        case (sel)
            1:       return 4;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives ncyc cycles into instance sel. Valid every 'period' cycles; din mode:
    // 0 constant k0, 1 ramp (cycle-1), 2 wrap table. Outputs from exp_q are due at
    // edges first_out + n*spacing; dout must hold between them.
    task automatic run_seq(input string name, input int sel, input int ncyc,
                           input int period, input int mode, input logic [20:0] k0,
                           input int first_out, input int spacing);
        int          nv;
        int          k;
        int          n_out;
        logic        vld;
        logic        exp_dv;
        logic [20:0] d;
        logic [31:0] last;
        nv    = 0;
        k     = 0;
        n_out = exp_q.size();
        last  = '0;
        for (int c = 1; c <= ncyc; c++) begin
            vld = ((c - 1) % period) == 0;
            case (mode)
                1:       d = 21'(c - 1);
                2:       d = (nv == 1) ? 21'h1FFFFF : ((nv % 2 == 1) ? 21'd1 : 21'd0);
                default: d = k0;
            endcase
            dv_in[sel]  = vld;
            din_in[sel] = d;
            if (vld) nv++;
            @(posedge clk);
            #1;
            exp_dv = (c >= first_out) && (((c - first_out) % spacing) == 0) && (k < n_out);
            chk($sformatf("%s dout_valid c=%0d", name, c), {31'b0, dv_o[sel]}, {31'b0, exp_dv});
            if (exp_dv) begin
                last = exp_q[k];
                k++;
            end
            chk($sformatf("%s dout c=%0d", name, c), dout_o[sel], last);
            chk($sformatf("%s phase c=%0d", name, c), {24'b0, ph_o[sel]}, 32'(nv % r_of(sel)));
        end
        dv_in[sel] = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4; i++) begin
            dv_in[i]  = 1'b0;
            din_in[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset dout_valid u%0d", i), {31'b0, dv_o[i]}, 32'd0);
            chk($sformatf("reset dout u%0d", i), dout_o[i], 32'd0);
            chk($sformatf("reset phase u%0d", i), {24'b0, ph_o[i]}, 32'd0);
        end
        rst = 1'b0;

        // Constant 5, R=8: third difference of a step.
        exp_q = '{e21(5), e21(-10), e21(5), e21(0), e21(0)};
        run_seq("impulse", 0, 46, 1, 0, 21'd5, 12, 8);

        // Valid every 3rd cycle: 8th valid at edge 22, 16th at 46.
        do_reset();
        exp_q = '{e21(5), e21(-10)};
        run_seq("gapped", 0, 52, 3, 0, 21'd5, 26, 24);

        // Ramp, R=4: decimated 3,7,11,15,19.
        do_reset();
        exp_q = '{e21(3), e21(-2), e21(-1), e21(0), e21(0)};
        run_seq("ramp", 1, 24, 1, 1, 21'd0, 8, 4);

        // Wrap, R=2: decimated -1,1,1,1,1 across the 21-bit boundary.
        do_reset();
        exp_q = '{e21(-1), e21(4), e21(-5), e21(2), e21(0)};
        run_seq("wrap", 2, 14, 1, 2, 21'd0, 6, 2);

        // Reset while the second decimated sample sits in comb stage 2.
        do_reset();
        exp_q = '{e21(5)};
        run_seq("pre_rst", 0, 18, 1, 0, 21'd5, 12, 8);
        rst = 1'b1;
        #1;
        chk("midrst dout_valid", {31'b0, dv_o[0]}, 32'd0);
        chk("midrst dout", dout_o[0], 32'd0);
        chk("midrst phase", {24'b0, ph_o[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst held dout_valid", {31'b0, dv_o[0]}, 32'd0);
        rst = 1'b0;
        exp_q = '{e21(5)};
        run_seq("post_rst", 0, 13, 1, 0, 21'd5, 12, 8);

        // Scaling 21->12 bits: 768 truncates to 1 (rounds to 2); -1536 gives -3.
        do_reset();
        exp_q = '{e12(SC768), e12(-3)};
        run_seq("scale768", 3, 20, 1, 0, 21'd768, 12, 8);

        // 0x0FFFFF: max positive code either way; second output wraps to y3=2.
        do_reset();
        exp_q = '{e12(12'h7FF), e12(0)};
        run_seq("scale_max", 3, 20, 1, 0, 21'h0FFFFF, 12, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
